// File: rtl/score_controller.sv
// score_controller: Pong match sequencer. Owns both scores, runs the
// serve/play/game-over flow, gates ball motion and time-shares one digit
// generator between the left and right score digits.
module score_controller #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [11:0] LEFT_OFFSET  = 12'd280,
    parameter logic [11:0] RIGHT_OFFSET = 12'd344
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        goal_left,
    input  logic        goal_right,
    input  logic        restart,
    input  logic [11:0] x,
    output logic [2:0]  score_left,
    output logic [2:0]  score_right,
    output logic        ball_enable,
    output logic [1:0]  winner,
    output logic [2:0]  gen_score,
    output logic [11:0] gen_offset,
    output logic        digit_visible
);

    localparam int unsigned SCORE_W = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned WIN_W   = 2;

    localparam logic [WIN_W-1:0] WIN_NONE  = 2'b00;
    localparam logic [WIN_W-1:0] WIN_LEFT  = 2'b01;
    localparam logic [WIN_W-1:0] WIN_RIGHT = 2'b10;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_blink;
    logic [SCORE_W-1:0]   r_score_left;
    logic [SCORE_W-1:0]   r_score_right;
    logic [WIN_W-1:0]     r_winner;
    logic                 r_ball_enable;
    logic [SCORE_W-1:0]   r_gen_score;
    logic [11:0]          r_gen_offset;
    logic                 r_digit_visible;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_blink_nxt;
    logic [SCORE_W-1:0]   w_score_left_nxt;
    logic [SCORE_W-1:0]   w_score_right_nxt;
    logic [WIN_W-1:0]     w_winner_nxt;
    logic [CNT_W:0]       w_cnt_inc;
    logic [SCORE_W-1:0]   w_left_inc;
    logic [SCORE_W-1:0]   w_right_inc;
    logic                 w_right_side;
    logic                 w_left_mask;
    logic                 w_right_mask;

    // Counter and score increments; one extra counter bit keeps the compare exact at 255
    assign w_cnt_inc   = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_left_inc  = r_score_left + SCORE_W'(1);
    assign w_right_inc = r_score_right + SCORE_W'(1);

    // Next-state logic for the match FSM, counter, blink phase, scores and winner
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_blink_nxt       = r_blink;
        w_score_left_nxt  = r_score_left;
        w_score_right_nxt = r_score_right;
        w_winner_nxt      = r_winner;

        if (restart) begin
            w_state_nxt       = ST_SERVE;
            w_cnt_nxt         = '0;
            w_blink_nxt       = 1'b0;
            w_score_left_nxt  = '0;
            w_score_right_nxt = '0;
            w_winner_nxt      = WIN_NONE;
        end else begin
            case (r_state)
                ST_SERVE: begin
                    if (frame_start) begin
                        if (w_cnt_inc == (CNT_W+1)'(SERVE_FRAMES)) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_PLAY;
                        end else begin
                            w_cnt_nxt = CNT_W'(w_cnt_inc);
                        end
                    end
                end
                ST_PLAY: begin
                    // Simultaneous goals cancel each other out
                    if (goal_left && !goal_right) begin
                        w_score_left_nxt = w_left_inc;
                        w_cnt_nxt        = '0;
                        if (w_left_inc == SCORE_W'(WIN_SCORE)) begin
                            w_state_nxt  = ST_OVER;
                            w_winner_nxt = WIN_LEFT;
                        end else begin
                            w_state_nxt = ST_SERVE;
                        end
                    end else if (goal_right && !goal_left) begin
                        w_score_right_nxt = w_right_inc;
                        w_cnt_nxt         = '0;
                        if (w_right_inc == SCORE_W'(WIN_SCORE)) begin
                            w_state_nxt  = ST_OVER;
                            w_winner_nxt = WIN_RIGHT;
                        end else begin
                            w_state_nxt = ST_SERVE;
                        end
                    end
                end
                ST_OVER: begin
                    if (frame_start) begin
                        if (w_cnt_inc == (CNT_W+1)'(BLINK_FRAMES)) begin
                            w_cnt_nxt   = '0;
                            w_blink_nxt = ~r_blink;
                        end else begin
                            w_cnt_nxt = CNT_W'(w_cnt_inc);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_SERVE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Match state registers; ball_enable is registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_SERVE;
            r_cnt         <= '0;
            r_blink       <= 1'b0;
            r_score_left  <= '0;
            r_score_right <= '0;
            r_winner      <= WIN_NONE;
            r_ball_enable <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_blink       <= w_blink_nxt;
            r_score_left  <= w_score_left_nxt;
            r_score_right <= w_score_right_nxt;
            r_winner      <= w_winner_nxt;
            r_ball_enable <= (w_state_nxt == ST_PLAY);
        end
    end

    // Side select and per-side blink masks; the winner's digit hides while blink is high
    assign w_right_side = (x >= RIGHT_OFFSET);
    assign w_left_mask  = !(r_blink && (r_winner == WIN_LEFT));
    assign w_right_mask = !(r_blink && (r_winner == WIN_RIGHT));

    // Digit generator mux, registered one cycle behind x
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen_score     <= '0;
            r_gen_offset    <= LEFT_OFFSET;
            r_digit_visible <= 1'b1;
        end else if (w_right_side) begin
            r_gen_score     <= r_score_right;
            r_gen_offset    <= RIGHT_OFFSET;
            r_digit_visible <= w_right_mask;
        end else begin
            r_gen_score     <= r_score_left;
            r_gen_offset    <= LEFT_OFFSET;
            r_digit_visible <= w_left_mask;
        end
    end

    assign score_left    = r_score_left;
    assign score_right   = r_score_right;
    assign ball_enable   = r_ball_enable;
    assign winner        = r_winner;
    assign gen_score     = r_gen_score;
    assign gen_offset    = r_gen_offset;
    assign digit_visible = r_digit_visible;

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller with default parameters. Expected
// values are queued as stimulus is applied and popped when outputs are read.
module tb_score_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        goal_left = 1'b0;
    logic        goal_right = 1'b0;
    logic        restart = 1'b0;
    logic [11:0] x = 12'd0;
    logic [2:0]  score_left;
    logic [2:0]  score_right;
    logic        ball_enable;
    logic [1:0]  winner;
    logic [2:0]  gen_score;
    logic [11:0] gen_offset;
    logic        digit_visible;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    score_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .goal_left     (goal_left),
        .goal_right    (goal_right),
        .restart       (restart),
        .x             (x),
        .score_left    (score_left),
        .score_right   (score_right),
        .ball_enable   (ball_enable),
        .winner        (winner),
        .gen_score     (gen_score),
        .gen_offset    (gen_offset),
        .digit_visible (digit_visible)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        total = total + 1;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: got %0d required an expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) passed = passed + 1;
            else $error("FAIL %s: got %0d required %0d", e.tag, obs, e.exp);
        end
    endtask

    task automatic goal(input logic l, input logic r);
        goal_left  = l;
        goal_right = r;
        tick();
        goal_left  = 1'b0;
        goal_right = 1'b0;
    endtask

    task automatic serve();
        repeat (60) pulse_frame();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        push("rst_score_left", 0);   pop_check(32'(score_left));
        push("rst_score_right", 0);  pop_check(32'(score_right));
        push("rst_winner", 0);       pop_check(32'(winner));
        push("rst_ball_enable", 0);  pop_check(32'(ball_enable));
        push("rst_gen_score", 0);    pop_check(32'(gen_score));
        push("rst_gen_offset", 280); pop_check(32'(gen_offset));
        push("rst_digit_vis", 1);    pop_check(32'(digit_visible));
        rst_n = 1'b1;
        tick();

        // First serve: 59 frames keep the ball held, the 60th releases it
        repeat (59) pulse_frame();
        push("serve59_ball_enable", 0); pop_check(32'(ball_enable));
        pulse_frame();
        push("serve60_ball_enable", 1); pop_check(32'(ball_enable));
        push("serve_score_left", 0);    pop_check(32'(score_left));
        push("serve_score_right", 0);   pop_check(32'(score_right));

        // Three left goals with serves in between; goals during SERVE are ignored
        for (int i = 1; i <= 3; i++) begin
            goal(1'b1, 1'b0);
            push("goal_l_score_left", 32'(i)); pop_check(32'(score_left));
            push("goal_l_ball_off", 0);        pop_check(32'(ball_enable));
            if (i == 1) begin
                goal(1'b1, 1'b0);
                goal(1'b0, 1'b1);
                push("serve_goal_ign_left", 1);  pop_check(32'(score_left));
                push("serve_goal_ign_right", 0); pop_check(32'(score_right));
            end
            serve();
            push("goal_l_reserve", 1); pop_check(32'(ball_enable));
        end
        push("three_goals_right", 0); pop_check(32'(score_right));

        // Digit mux with one-cycle latency and the side boundary
        x = 12'd290;
        tick();
        push("mux290_score", 3);    pop_check(32'(gen_score));
        push("mux290_offset", 280); pop_check(32'(gen_offset));
        x = 12'd350;
        push("mux_latency_hold", 3); pop_check(32'(gen_score));
        tick();
        push("mux350_score", 0);    pop_check(32'(gen_score));
        push("mux350_offset", 344); pop_check(32'(gen_offset));
        x = 12'd343;
        tick();
        push("mux343_offset", 280); pop_check(32'(gen_offset));
        x = 12'd344;
        tick();
        push("mux344_offset", 344); pop_check(32'(gen_offset));

        // Simultaneous goals in PLAY are both ignored
        goal(1'b1, 1'b1);
        push("both_left", 3);      pop_check(32'(score_left));
        push("both_right", 0);     pop_check(32'(score_right));
        push("both_still_play", 1); pop_check(32'(ball_enable));

        // Right player to 6, then the winning goal
        for (int i = 1; i <= 6; i++) begin
            goal(1'b0, 1'b1);
            serve();
        end
        push("right_six", 6); pop_check(32'(score_right));
        goal(1'b0, 1'b1);
        push("win_score_right", 7); pop_check(32'(score_right));
        push("win_winner", 2);      pop_check(32'(winner));
        push("win_ball_off", 0);    pop_check(32'(ball_enable));

        // Goals in OVER are ignored
        goal(1'b1, 1'b0);
        push("over_goal_ign", 3); pop_check(32'(score_left));

        // Blink: right digit hides after 30 frames, left digit stays visible
        x = 12'd350;
        repeat (29) pulse_frame();
        tick();
        push("blink29_right_vis", 1); pop_check(32'(digit_visible));
        pulse_frame();
        tick();
        push("blink30_right_hid", 0); pop_check(32'(digit_visible));
        x = 12'd290;
        tick();
        push("blink_left_vis", 1); pop_check(32'(digit_visible));
        x = 12'd350;
        repeat (30) pulse_frame();
        tick();
        push("blink60_right_vis", 1); pop_check(32'(digit_visible));
        push("over_no_serve", 0);     pop_check(32'(ball_enable));

        // Restart wins over frame_start and goal in the same cycle
        restart     = 1'b1;
        frame_start = 1'b1;
        goal_left   = 1'b1;
        tick();
        restart     = 1'b0;
        frame_start = 1'b0;
        goal_left   = 1'b0;
        push("restart_left", 0);   pop_check(32'(score_left));
        push("restart_right", 0);  pop_check(32'(score_right));
        push("restart_winner", 0); pop_check(32'(winner));
        push("restart_ball", 0);   pop_check(32'(ball_enable));
        repeat (59) pulse_frame();
        push("restart_cnt59", 0); pop_check(32'(ball_enable));
        pulse_frame();
        push("restart_cnt60", 1); pop_check(32'(ball_enable));

        // Left to 5, then async reset mid-PLAY
        for (int i = 1; i <= 5; i++) begin
            goal(1'b1, 1'b0);
            serve();
        end
        x = 12'd290;
        tick();
        push("pre_rst_left", 5); pop_check(32'(score_left));
        push("pre_rst_gen", 5);  pop_check(32'(gen_score));
        #2;
        rst_n = 1'b0;
        #1;
        push("async_left", 0);  pop_check(32'(score_left));
        push("async_ball", 0);  pop_check(32'(ball_enable));
        push("async_gen", 0);   pop_check(32'(gen_score));
        push("async_vis", 1);   pop_check(32'(digit_visible));
        push("async_off", 280); pop_check(32'(gen_offset));
        push("async_win", 0);   pop_check(32'(winner));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/score_controller.md
# score_controller

Match sequencer for Pong that owns both players' 3-bit scores and the serve/play/game-over flow. It time-shares a single `score_generator` instance between the left and right digits by multiplexing `score` and `horizontal_offset` on pixel x. It also gates ball motion and blinks the winner's digit at game end. It sits between the ball/collision logic, which reports goals, and the score digit renderer.

## Interface
Parameters:
- `WIN_SCORE`, default 7: score that ends the match; legal range 1..7.
- `SERVE_FRAMES`, default 60: frames the ball is held before each serve; legal range 1..255.
- `BLINK_FRAMES`, default 30: frames per blink half-period in game over; legal range 1..255.
- `LEFT_OFFSET`, default 12'd280: x origin of the left digit.
- `RIGHT_OFFSET`, default 12'd344: x origin of the right digit; must be ≥ `LEFT_OFFSET` + 16.

Ports:
- `clk`  in  1  pixel clock; one clock drives the whole block.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `frame_start`  in  1  one-cycle pulse, once per frame.
- `goal_left`  in  1  one-cycle pulse: left player scored.
- `goal_right`  in  1  one-cycle pulse: right player scored.
- `restart`  in  1  one-cycle pulse: start a new match.
- `x`  in  12  current pixel x coordinate.
- `score_left`  out  3  left player's score.
- `score_right`  out  3  right player's score.
- `ball_enable`  out  1  1 = ball may move.
- `winner`  out  2  00 = none, 01 = left, 10 = right.
- `gen_score`  out  3  score value to the digit generator.
- `gen_offset`  out  12  horizontal offset to the digit generator.
- `digit_visible`  out  1  AND-mask applied to the generator output.

## Operation
- FSM states: SERVE, PLAY, OVER. Reset enters SERVE.
- Reset values: scores 0, winner 00, ball_enable 0, gen_score 0, gen_offset `LEFT_OFFSET`, digit_visible 1. Frame counter and blink phase are also 0.
- SERVE:
  - ball_enable is 0.
  - The 8-bit frame counter increments on each `frame_start`.
  - On the `frame_start` that makes the count reach `SERVE_FRAMES`, the counter clears and the FSM moves to PLAY.
- PLAY:
  - ball_enable is 1.
  - `goal_left` alone increments score_left. `goal_right` alone increments score_right.
  - After an increment, the FSM goes to OVER if the new score equals `WIN_SCORE`; winner is set to 01 or 10 in the same cycle. Otherwise the FSM returns to SERVE with the counter cleared.
  - If `goal_left` and `goal_right` are both asserted in the same cycle, both are ignored and the FSM stays in PLAY.
- Goal pulses in SERVE or OVER are ignored. Scores never exceed `WIN_SCORE`, so no wrap-around is possible.
- OVER:
  - ball_enable is 0.
  - The counter counts `frame_start` pulses. When it reaches `BLINK_FRAMES`, it clears and the blink phase toggles.
  - While blink phase is 1, the winner's digit is hidden (digit_visible = 0 on its side). The loser's digit stays visible.
- `restart` in any state:
  - Clears scores, winner, counter and blink phase, and enters SERVE.
  - Takes priority over goals and over `frame_start` in the same cycle.
- Digit mux, evaluated every cycle:
  - If x < `RIGHT_OFFSET`: gen_score = score_left, gen_offset = `LEFT_OFFSET`, and digit_visible is the left-side mask.
  - Otherwise the same outputs take the right-side score, offset and mask.
- Score outputs and winner come straight from registers and update on the clock edge after the triggering pulse.

## Timing
- gen_score, gen_offset and digit_visible are registered: they reflect the `x` presented one cycle earlier.
- The integrator delays `x`/`y` into `score_generator` by one cycle to stay aligned. Total digit pixel latency is 2 cycles.
- Goal to score update: 1 cycle. The new score appears on the gen_* outputs 1 cycle later at matching x.
- PLAY → SERVE → PLAY: ball_enable drops the cycle after the goal and rises the cycle after the `SERVE_FRAMES`-th `frame_start`.
- Blink period in OVER is 2 × `BLINK_FRAMES` frames.
- `rst_n` asserted mid-frame forces all outputs to their reset values immediately, independent of `clk`. Deassertion is synchronous to the next `clk` edge.

## Test plan
- Reset, then 60 `frame_start` pulses (default parameters): ball_enable stays 0 through pulse 59 and reads 1 one cycle after pulse 60; scores 0/0.
- In PLAY, pulse `goal_left` three times with serves in between: score_left = 3, score_right = 0, state returns to SERVE after each goal; the mux presents 3 at x = 290 and 0 at x = 350 with 1-cycle latency.
- Drive score_right to 6, then pulse `goal_right`: score_right = 7, winner = 10, ball_enable = 0. The right digit's digit_visible toggles every 30 frames; the left digit's stays 1.
- In PLAY, assert `goal_left` and `goal_right` together: both scores unchanged, state remains PLAY. Goal pulses during SERVE leave scores unchanged.
- Assert `restart` in OVER in the same cycle as `frame_start` and `goal_left`: scores 0/0, winner 00, SERVE entered, counter 0.
- Assert `rst_n` low mid-PLAY with score_left = 5: all outputs take their reset values without waiting for a clock edge.
